// File: rtl/arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    // Wide enough for any supported DW; sliced to DW/8 where used.
    localparam int                    BE_MAX_W = 64;
    localparam logic [BE_MAX_W-1:0]   BE_ALL   = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signals of the fetch/LSU memory port arbiter.
// The master modport is the arbiter's view (it masters the memory bus); slave is the environment's.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [BW-1:0] bus_be;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    logic          stall;
    logic          err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, bus_ack, bus_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be, stall, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, bus_ack, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be, stall, err
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for an outstanding bus transaction; expired fires on the
// TIMEOUT-th cycle spent waiting for bus_ack. Used only when ARB_TIMEOUT_EN is defined.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    assign expired = run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory bus shared between instruction fetch and load/store, one transaction
// outstanding. Optional bus_ack timeout with sticky err is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int BW = DW / 8;

    state_t        r_state;
    logic          r_last_was_data;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic [BW-1:0] r_bus_be;
    logic          r_if_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_idle;
    logic          w_busy;
    logic          w_d_gnt;
    logic          w_if_gnt;
    logic          w_done;
    logic          w_expired;

    // Grants are combinational, so they are masked while reset holds the outputs at zero.
    assign w_idle   = rst && (r_state == ST_IDLE);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_d_gnt  = w_idle && bus.d_req && (!bus.if_req || !r_last_was_data);
    assign w_if_gnt = w_idle && bus.if_req && !w_d_gnt;
    assign w_done   = bus.bus_ack || w_expired;

`ifdef ARB_TIMEOUT_EN
    logic r_err;

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_d_gnt || w_if_gnt),
        .run     (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_expired && !bus.bus_ack) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_expired = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_last_was_data <= 1'b0;
            r_bus_req       <= 1'b0;
            r_bus_we        <= 1'b0;
            r_bus_addr      <= '0;
            r_bus_wdata     <= '0;
            r_bus_be        <= '0;
            r_if_rvalid     <= 1'b0;
            r_d_rvalid      <= 1'b0;
            r_if_rdata      <= '0;
            r_d_rdata       <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_d_gnt) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= bus.d_we;
                        r_bus_addr  <= bus.d_addr;
                        r_bus_wdata <= bus.d_wdata;
                        r_bus_be    <= bus.d_be;
                        r_state     <= ST_DATA;
                    end else if (w_if_gnt) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= bus.if_addr;
                        r_bus_wdata <= '0;
                        r_bus_be    <= BE_ALL[BW-1:0];
                        r_state     <= ST_FETCH;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_bus_req       <= 1'b0;
                        r_d_rvalid      <= 1'b1;
                        // Stores and aborted transactions return zero.
                        r_d_rdata       <= (bus.bus_ack && !r_bus_we) ? bus.bus_rdata : '0;
                        r_last_was_data <= 1'b1;
                        r_state         <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (w_done) begin
                        r_bus_req       <= 1'b0;
                        r_if_rvalid     <= 1'b1;
                        r_if_rdata      <= bus.bus_ack ? bus.bus_rdata : '0;
                        r_last_was_data <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_be    = r_bus_be;
    assign bus.stall     = w_busy;

endmodule
